tp_mem_pp: RTL and testbench

- Parametrised ping-pong transpose buffer. Successor to the single-bank transpose memory between DCT stages.
- Accepts an N×N block of BW-bit samples in row-major order and emits it column-major, i.e. transposed.
- Two banks let one block be written while the previous block is read, so streaming is continuous.
- Adds a ready/valid handshake on both sides, an end-of-block marker and an overflow indication.

---
 rtl/tp_mem_pp.sv | 125 ++++++++++++
 tb/tb_tp_mem_pp.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/tp_mem_pp.sv
// rtl/tp_mem_pp.sv - ping-pong N x N transpose buffer with ready/valid streams
// Define TP_ZIGZAG_EN to read in JPEG zig-zag order instead of the transpose (N must be 8).
module tp_mem_pp #(
    parameter int BW = 10,
    parameter int N  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [BW-1:0] data_in,
    input  logic          in_enb,
    output logic          in_rdy,
    output logic [BW-1:0] data_out,
    output logic          out_enb,
    input  logic          out_rdy,
    output logic          out_last,
    output logic          ovf
);

    localparam int AW = $clog2(N * N);
    localparam int LN = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N * N - 1);

    logic [BW-1:0] mem [2][N*N];
    logic [1:0]    full;
    logic          wr_bank;
    logic          rd_bank;
    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] rd_cnt;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic          wr_done;
    logic          rd_ld;
    logic          rd_done;

`ifdef TP_ZIGZAG_EN
    if (N != 8) begin : g_zz_bad
        $error("tp_mem_pp: TP_ZIGZAG_EN requires N == 8");
    end

    // Walk the anti-diagonals, alternating direction, to list raster addresses in zig-zag order.
    function automatic logic [N*N*AW-1:0] zz_table();
        logic [N*N*AW-1:0] t;
        int k, lo, hi, r;
        t = '0;
        k = 0;
        for (int s = 0; s < 2 * N - 1; s++) begin
            lo = (s > N - 1) ? s - (N - 1) : 0;
            hi = (s < N - 1) ? s : N - 1;
            for (int i = 0; i < N; i++) begin
                if (i <= hi - lo) begin
                    r = (s % 2 == 1) ? lo + i : hi - i;
                    t[k*AW +: AW] = AW'(r * N + (s - r));
                    k++;
                end
            end
        end
        return t;
    endfunction

    localparam logic [N*N*AW-1:0] ZZ = zz_table();

    assign rd_addr = ZZ[rd_cnt*AW +: AW];
`else
    // Swapping row and column fields of the raster index gives the transposed address.
    assign rd_addr = {rd_cnt[LN-1:0], rd_cnt[AW-1:LN]};
`endif

    assign in_rdy  = !full[wr_bank];
    assign wr_en   = in_enb && in_rdy;
    assign wr_done = wr_en && (wr_cnt == LAST);
    assign rd_ld   = full[rd_bank] && (!out_enb || out_rdy);
    assign rd_done = rd_ld && (rd_cnt == LAST);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_cnt] <= data_in;
        end
    end

    // Write completion and read release always target different banks, so both may fire together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
        end else begin
            if (wr_en) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            if (wr_done) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= !wr_bank;
            end
            if (rd_ld) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (rd_done) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= !rd_bank;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out <= '0;
            out_enb  <= 1'b0;
            out_last <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            ovf <= in_enb && !in_rdy;
            if (rd_ld) begin
                data_out <= mem[rd_bank][rd_addr];
                out_enb  <= 1'b1;
                out_last <= (rd_cnt == LAST);
            end else if (out_enb && out_rdy) begin
                out_enb  <= 1'b0;
                out_last <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tp_mem_pp.sv
// tb/tb_tp_mem_pp.sv - directed self-checking bench for tp_mem_pp
module tb_tp_mem_pp;

    localparam int BW = 10;
    localparam int N  = 8;
    localparam int NN = N * N;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [BW-1:0] data_in = '0;
    logic          in_enb = 1'b0;
    logic          in_rdy;
    logic [BW-1:0] data_out;
    logic          out_enb;
    logic          out_rdy = 1'b0;
    logic          out_last;
    logic          ovf;

    int n_checks = 0;
    int n_pass   = 0;
    int lat;

`ifdef TP_ZIGZAG_EN
    int zz [NN] = '{ 0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
                    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
                    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
                    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
`endif

    always #5 clk = ~clk;

    tp_mem_pp #(.BW(BW), .N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .in_enb   (in_enb),
        .in_rdy   (in_rdy),
        .data_out (data_out),
        .out_enb  (out_enb),
        .out_rdy  (out_rdy),
        .out_last (out_last),
        .ovf      (ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int exp_word(input int base, input int k);
        int j;
        j = k % NN;
`ifdef TP_ZIGZAG_EN
        return base + (k / NN) * NN + zz[j];
`else
        return base + (k / NN) * NN + (j % N) * N + j / N;
`endif
    endfunction

    task automatic do_reset();
        in_enb  = 1'b0;
        out_rdy = 1'b0;
        data_in = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Drive base..base+n_in-1 and check the first n_out output words; optional output stall.
    task automatic stream(input string name, input int base, input int n_in, input int n_out,
                          input int stall_at, input int stall_len, output int latency);
        int sent = 0, got = 0, cyc = 0, stalled = 0;
        int gaps = 0, rdy_low = 0, ovfs = 0, wr_cyc = -1, out_cyc = -1;
        while ((sent < n_in || got < n_out) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (ovf) ovfs++;
            if (out_enb && out_cyc < 0) out_cyc = cyc;
            if (out_cyc >= 0 && got < n_out && !out_enb) gaps++;
            in_enb  = (sent < n_in);
            data_in = BW'(base + sent);
            if (in_enb) begin
                if (in_rdy) begin
                    sent++;
                    if (sent == n_in) wr_cyc = cyc;
                end else begin
                    rdy_low++;
                end
            end
            out_rdy = !(got == stall_at && stalled < stall_len);
            if (!out_rdy) begin
                stalled++;
                check({name, "_stall_data"}, data_out, exp_word(base, got));
                check({name, "_stall_enb"}, out_enb, 1);
            end else if (out_enb && got < n_out) begin
                check({name, "_data"}, data_out, exp_word(base, got));
                check({name, "_last"}, out_last, ((got % NN) == NN - 1) ? 1 : 0);
                got++;
            end
        end
        in_enb = 1'b0;
        check({name, "_complete"}, (sent >= n_in && got >= n_out) ? 1 : 0, 1);
        check({name, "_gaps"}, gaps, 0);
        check({name, "_in_rdy_low"}, rdy_low, 0);
        check({name, "_ovf_seen"}, ovfs, 0);
        latency = out_cyc - wr_cyc;
    endtask

    initial begin
        #2;
        check("rst_data_out", data_out, 0);
        check("rst_out_enb", out_enb, 0);
        check("rst_out_last", out_last, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_in_rdy", in_rdy, 1);

        // single block: transpose order and one-cycle latency from last write
        stream("blk1", 0, 64, 64, -1, 0, lat);
        check("blk1_latency", lat, 2);

        // three back-to-back blocks, continuous flow
        do_reset();
        stream("b2b", 0, 192, 192, -1, 0, lat);

        // output held off: both banks fill, 129th sample dropped
        do_reset();
        out_rdy = 1'b0;
        for (int i = 0; i < 129; i++) begin
            @(negedge clk);
            in_enb  = 1'b1;
            data_in = BW'(i);
            if (i == 127) check("bp_rdy_127", in_rdy, 1);
            if (i == 128) check("bp_rdy_128", in_rdy, 0);
        end
        @(negedge clk);
        in_enb = 1'b0;
        check("bp_ovf_pulse", ovf, 1);
        check("bp_out_enb", out_enb, 1);
        check("bp_data_hold", data_out, 0);
        check("bp_out_last", out_last, 0);
        @(negedge clk);
        check("bp_ovf_single", ovf, 0);
        check("bp_rdy_still_low", in_rdy, 0);

        // stall at output index 10
        do_reset();
        stream("stall", 0, 64, 64, 10, 5, lat);

        // asynchronous reset mid-block, then a fresh block
        do_reset();
        stream("pre", 0, 94, 20, -1, 0, lat);
        @(negedge clk);
        check("pre_out_enb", out_enb, 1);
        check("pre_data_nonzero", (data_out != 0) ? 1 : 0, 1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_data_out", data_out, 0);
        check("arst_out_enb", out_enb, 0);
        check("arst_out_last", out_last, 0);
        check("arst_in_rdy", in_rdy, 1);
        @(negedge clk);
        rst = 1'b1;
        stream("fresh", 100, 64, 64, -1, 0, lat);
        check("fresh_latency", lat, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
